tipi_shift_tx: RTL and testbench

Serial transmitter for the TIPI RPi-to-TI register path: serializes one byte into either the RD (data) or RC (control) shift register of the TI-side CPLD. It drives the shared 4-wire interface (rpi_sdata, rpi_le, and one of rpi_dclk/rpi_cclk) from a single system clock. It is used in the RPi-side/bench-side glue and as the reference driver in CPLD verification.

---
 rtl/tipi_shift_tx.sv | 113 +++++++++++
 tb/tb_tipi_shift_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tipi_shift_tx.sv
// Serial transmitter into the TIPI CPLD RD/RC shift registers: eight shift
// pulses (MSB first) on the selected clock, then one latch pulse with le high.
module tipi_shift_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       rpi_dclk,
  output logic       rpi_cclk,
  output logic       rpi_sdata,
  output logic       rpi_le
);

  localparam logic [7:0] PH_LAST = 8'(DIV - 1);
  localparam logic [3:0] BIT_LE  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_shift;
  logic [3:0]  r_bit;
  logic [7:0]  r_phase;
  logic        r_sel;
  logic        r_done;
  logic        w_phase_tc;
  logic        w_busy;
  logic        w_high;

  assign w_phase_tc = (r_phase == PH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOW;
      end
      S_LOW: begin
        if (w_phase_tc) w_state_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (w_phase_tc) w_state_nxt = (r_bit == BIT_LE) ? S_IDLE : S_LOW;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The shift register only advances on HIGH->LOW, so sdata moves with the falling clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 8'd0;
      r_bit   <= 4'd0;
      r_phase <= 8'd0;
      r_sel   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= din;
            r_sel   <= sel;
            r_bit   <= 4'd0;
            r_phase <= 8'd0;
          end
        end
        S_LOW: begin
          r_phase <= w_phase_tc ? 8'd0 : r_phase + 8'd1;
        end
        S_HIGH: begin
          r_phase <= w_phase_tc ? 8'd0 : r_phase + 8'd1;
          if (w_phase_tc) begin
            if (r_bit == BIT_LE) begin
              r_done <= 1'b1;
            end else begin
              r_shift <= {r_shift[6:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
            end
          end
        end
        default: r_phase <= 8'd0;
      endcase
    end
  end

  assign w_busy    = (r_state != S_IDLE);
  assign w_high    = (r_state == S_HIGH);

  assign busy      = w_busy;
  assign done      = r_done;
  assign rpi_dclk  = w_high & ~r_sel;
  assign rpi_cclk  = w_high & r_sel;
  assign rpi_sdata = w_busy & (r_bit != BIT_LE) & r_shift[7];
  assign rpi_le    = w_busy & (r_bit == BIT_LE);

endmodule

// File: tb/tb_tipi_shift_tx.sv
// Bench for tipi_shift_tx: three instances (DIV=4/1/255) feed one receiver
// model; latched bytes are checked against a scoreboard of sent payloads.
module tb_tipi_shift_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, start1, start255;
  logic       sel;
  logic [7:0] din;

  logic busy4, done4, dclk4, cclk4, sdata4, le4;
  logic busy1, done1, dclk1, cclk1, sdata1, le1;
  logic busy255, done255, dclk255, cclk255, sdata255, le255;

  tipi_shift_tx #(.DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sel(sel), .din(din),
    .busy(busy4), .done(done4), .rpi_dclk(dclk4), .rpi_cclk(cclk4),
    .rpi_sdata(sdata4), .rpi_le(le4)
  );

  tipi_shift_tx #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sel(sel), .din(din),
    .busy(busy1), .done(done1), .rpi_dclk(dclk1), .rpi_cclk(cclk1),
    .rpi_sdata(sdata1), .rpi_le(le1)
  );

  tipi_shift_tx #(.DIV(255)) u_dut255 (
    .clk(clk), .rst(rst), .start(start255), .sel(sel), .din(din),
    .busy(busy255), .done(done255), .rpi_dclk(dclk255), .rpi_cclk(cclk255),
    .rpi_sdata(sdata255), .rpi_le(le255)
  );

  // Idle instances drive all pins low, so OR-ing gives the active one.
  logic any_busy, any_done, any_dclk, any_cclk, any_sdata, any_le;
  assign any_busy  = busy4 | busy1 | busy255;
  assign any_done  = done4 | done1 | done255;
  assign any_dclk  = dclk4 | dclk1 | dclk255;
  assign any_cclk  = cclk4 | cclk1 | cclk255;
  assign any_sdata = sdata4 | sdata1 | sdata255;
  assign any_le    = le4 | le1 | le255;

  logic [17:0] all_outs;
  assign all_outs = {busy4, done4, dclk4, cclk4, sdata4, le4,
                     busy1, done1, dclk1, cclk1, sdata1, le1,
                     busy255, done255, dclk255, cclk255, sdata255, le255};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       s;
    logic [7:0] b;
  } exp_t;
  exp_t sbq[$];

  task automatic sb_check(input logic s, input logic [7:0] v);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_latch", 32'(v), 32'hFFFF_FFFF);
    end else begin
      e = sbq.pop_front();
      chk("latch_target", 32'(s), 32'(e.s));
      chk("latch_byte", 32'(v), 32'(e.b));
    end
  endtask

  // Receiver model of the CPLD RD/RC registers.
  logic [7:0] d_sr = 8'd0, d_latch = 8'd0, c_sr = 8'd0, c_latch = 8'd0;
  logic [8:0] d_bits = 9'd0, le_bits = 9'd0;
  int n_dedge = 0, n_cedge = 0, n_le = 0;

  always @(posedge any_dclk) begin
    n_dedge++;
    d_bits  = {d_bits[7:0], any_sdata};
    le_bits = {le_bits[7:0], any_le};
    if (any_le) begin
      d_latch = d_sr;
      n_le++;
      sb_check(1'b0, d_sr);
    end else begin
      d_sr = {d_sr[6:0], any_sdata};
    end
  end

  always @(posedge any_cclk) begin
    n_cedge++;
    if (any_le) begin
      c_latch = c_sr;
      n_le++;
      sb_check(1'b1, c_sr);
    end else begin
      c_sr = {c_sr[6:0], any_sdata};
    end
  end

  // Per-cycle monitor: busy length, done pulses and shift-clock level run lengths.
  int busy_cnt = 0, done_cnt = 0, run = 0;
  logic in_xfer = 1'b0, lvl = 1'b0;
  int runs[$];

  always @(negedge clk) begin
    if (any_busy) begin
      busy_cnt++;
      if (!in_xfer) begin
        in_xfer = 1'b1;
        run = 1;
        lvl = any_dclk | any_cclk;
      end else if ((any_dclk | any_cclk) == lvl) begin
        run++;
      end else begin
        runs.push_back(run);
        run = 1;
        lvl = any_dclk | any_cclk;
      end
    end else if (in_xfer) begin
      runs.push_back(run);
      in_xfer = 1'b0;
    end
    if (any_done) done_cnt++;
  end

  task automatic clr();
    n_dedge = 0; n_cedge = 0; busy_cnt = 0; done_cnt = 0;
    d_bits = 9'd0; le_bits = 9'd0;
    runs.delete();
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start4 = v;
      1: start1 = v;
      default: start255 = v;
    endcase
  endtask

  // Returns at the negedge right after the acceptance edge (cycle 0).
  task automatic send(input int which, input logic s, input logic [7:0] b);
    @(negedge clk);
    sel = s;
    din = b;
    set_start(which, 1'b1);
    sbq.push_back({s, b});
    @(negedge clk);
    set_start(which, 1'b0);
    sel = ~s;
    din = ~b;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!any_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(any_done), 32'd1);
  endtask

  task automatic check_runs(input string tag, input int exp_n, input int div);
    int bad;
    bad = 0;
    chk({tag, "_nruns"}, 32'(runs.size()), 32'(exp_n));
    foreach (runs[i]) if (runs[i] != div) bad++;
    chk({tag, "_runlen"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] pre_latch;
    int         pre_le;

    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start255 = 1'b0;
    sel = 1'b0; din = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(all_outs), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // DIV=4, data register, 0xA5
    clr();
    send(0, 1'b0, 8'hA5);
    chk("t0_busy", 32'(any_busy), 32'd1);
    chk("t0_sdata", 32'(any_sdata), 32'd1);
    chk("t0_clk_low", 32'({any_dclk, any_cclk, any_le}), 32'd0);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("a5_dedges", 32'(n_dedge), 32'd9);
    chk("a5_cedges", 32'(n_cedge), 32'd0);
    chk("a5_sdata_bits", 32'(d_bits), 32'h14A);
    chk("a5_le_bits", 32'(le_bits), 32'h001);
    chk("a5_busy_len", 32'(busy_cnt), 32'd72);
    chk("a5_done_cnt", 32'(done_cnt), 32'd1);
    chk("a5_latch", 32'(d_latch), 32'hA5);
    check_runs("a5", 18, 4);

    // Control register 0x3C, then data 0xFF
    clr();
    send(0, 1'b1, 8'h3C);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("3c_cedges", 32'(n_cedge), 32'd9);
    chk("3c_dedges", 32'(n_dedge), 32'd0);
    chk("3c_clatch", 32'(c_latch), 32'h3C);
    clr();
    send(0, 1'b0, 8'hFF);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("ff_dlatch", 32'(d_latch), 32'hFF);
    chk("ff_clatch_kept", 32'(c_latch), 32'h3C);

    // DIV=1, start held high: back-to-back transfers
    clr();
    @(negedge clk);
    sel = 1'b0; din = 8'h01; start1 = 1'b1;
    sbq.push_back({1'b0, 8'h01});
    @(negedge clk);
    chk("b2b_t0_busy", 32'(any_busy), 32'd1);
    din = 8'h80;
    sbq.push_back({1'b0, 8'h80});
    wait_done(40);
    chk("b2b_len1", 32'(busy_cnt), 32'd18);
    chk("b2b_gap_idle", 32'(any_busy), 32'd0);
    busy_cnt = 0;
    @(negedge clk);
    chk("b2b_restart", 32'(any_busy), 32'd1);
    din = 8'h55;
    wait_done(40);
    start1 = 1'b0;
    chk("b2b_len2", 32'(busy_cnt), 32'd18);
    repeat (3) @(negedge clk);
    chk("b2b_latch2", 32'(d_latch), 32'h80);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_dedges", 32'(n_dedge), 32'd18);
    check_runs("b2b", 36, 1);

    // start pulses while busy at cycles 5 and 40
    clr();
    send(0, 1'b0, 8'h96);
    repeat (5) @(negedge clk);
    din = 8'h11; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (34) @(negedge clk);
    din = 8'h22; sel = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done(100);
    repeat (80) @(negedge clk);
    chk("busy_start_dedges", 32'(n_dedge + n_cedge), 32'd9);
    chk("busy_start_done", 32'(done_cnt), 32'd1);
    chk("busy_start_latch", 32'(d_latch), 32'h96);
    chk("busy_start_bustime", 32'(busy_cnt), 32'd72);

    // Reset at cycle 30 of a 0x5A transfer
    clr();
    pre_latch = d_latch;
    pre_le = n_le;
    send(0, 1'b0, 8'h5A);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", 32'(all_outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_le", 32'(n_le), 32'(pre_le));
    chk("abort_latch_kept", 32'(d_latch), 32'(pre_latch));
    chk("abort_pending", 32'(sbq.size()), 32'd1);
    sbq.delete();
    clr();
    send(0, 1'b0, 8'hC3);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("after_abort_latch", 32'(d_latch), 32'hC3);
    chk("after_abort_dedges", 32'(n_dedge), 32'd9);

    // DIV=255, 0x00
    clr();
    send(2, 1'b0, 8'h00);
    wait_done(5000);
    repeat (3) @(negedge clk);
    chk("d255_busy_len", 32'(busy_cnt), 32'd4590);
    chk("d255_dedges", 32'(n_dedge), 32'd9);
    chk("d255_latch", 32'(d_latch), 32'h00);
    check_runs("d255", 18, 255);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
